// File: rtl/move_pkg.sv
// Shared types for the move input conditioner.
//   dir_e    : direction index; also the arbitration priority order (up wins)
//   NUM_DIRS : number of direction keys
//   max2     : helper used to size the shared repeat timer
package move_pkg;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;

  localparam int NUM_DIRS = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/key_conditioner.sv
// Conditions one raw direction key: 2-flop sync, debounce, press-edge
// detect and optional auto-repeat.
//   clk, reset : clock, async active-high reset
//   en         : 0 suppresses events and parks the repeat timer
//   key_i      : raw key level, asynchronous to clk
//   held_o     : debounced pressed level (1 = pressed)
//   event_o    : combinational candidate event (press or repeat)
module key_conditioner
  import move_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic key_i,
  output logic held_o,
  output logic event_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic          REL    = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] DLY    = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0] PER    = TW'(REPEAT_PERIOD);

  logic          sync1_q, sync2_q;
  logic          held_q, held_d, hprev_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          rep_act_q, rep_act_d, rep_per_q, rep_per_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pressed, rise, ev;

  assign pressed = sync2_q ^ REL;
  assign rise    = held_q & ~hprev_q;

  // Counter sits at DB_MAX for one cycle before the level flips, so it
  // never exceeds DB_MAX and needs no separate saturation check.
  always_comb begin
    held_d   = held_q;
    db_cnt_d = '0;
    if (db_cnt_q == DB_MAX)   held_d   = ~held_q;
    else if (pressed != held_q) db_cnt_d = db_cnt_q + DW'(1);
  end

  // Timer counts cycles since the last event; target is DLY before the
  // first repeat and PER afterwards. Released key or en=0 parks it.
  always_comb begin
    rep_act_d = rep_act_q;
    rep_per_d = rep_per_q;
    tmr_d     = tmr_q;
    ev        = 1'b0;
    if (!en || !held_q) begin
      rep_act_d = 1'b0;
      rep_per_d = 1'b0;
      tmr_d     = '0;
    end else if (rise) begin
      ev        = 1'b1;
      rep_act_d = (REPEAT_DELAY > 0);
      rep_per_d = 1'b0;
      tmr_d     = TW'(1);
    end else if (rep_act_q) begin
      if (tmr_q == (rep_per_q ? PER : DLY)) begin
        ev        = 1'b1;
        rep_per_d = 1'b1;
        tmr_d     = TW'(1);
      end else begin
        tmr_d = tmr_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= REL;
      sync2_q   <= REL;
      held_q    <= 1'b0;
      hprev_q   <= 1'b0;
      db_cnt_q  <= '0;
      rep_act_q <= 1'b0;
      rep_per_q <= 1'b0;
      tmr_q     <= '0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      held_q    <= held_d;
      hprev_q   <= held_q;
      db_cnt_q  <= db_cnt_d;
      rep_act_q <= rep_act_d;
      rep_per_q <= rep_per_d;
      tmr_q     <= tmr_d;
    end
  end

  assign held_o  = held_q;
  assign event_o = ev;
endmodule

// File: rtl/move_input_conditioner.sv
// Turns four raw bouncy direction keys into clean one-cycle move pulses,
// at most one direction per cycle (priority up > down > left > right).
//   clk, reset                     : clock, async active-high reset
//   en                             : 0 forces all pulses low
//   key_up/down/left/right         : raw keys, asynchronous
//   up/down/left/right             : registered one-cycle pulses
//   held                           : debounced levels {up,down,left,right}
module move_input_conditioner
  import move_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] held
);
  logic [NUM_DIRS-1:0] key_raw, held_v, ev_v, win, out_q;

  // Indexed by dir_e: bit 0 = up ... bit 3 = right.
  assign key_raw = {key_right, key_left, key_down, key_up};

  for (genvar k = 0; k < NUM_DIRS; k++) begin : g_key
    key_conditioner #(
      .ACTIVE_LOW     (ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_key (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .key_i  (key_raw[k]),
      .held_o (held_v[k]),
      .event_o(ev_v[k])
    );
  end

  // Fixed priority; losers are simply dropped.
  always_comb begin
    win = '0;
    if (ev_v[DIR_UP])         win[DIR_UP]    = 1'b1;
    else if (ev_v[DIR_DOWN])  win[DIR_DOWN]  = 1'b1;
    else if (ev_v[DIR_LEFT])  win[DIR_LEFT]  = 1'b1;
    else if (ev_v[DIR_RIGHT]) win[DIR_RIGHT] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_q <= '0;
    else       out_q <= en ? win : '0;
  end

  assign up    = out_q[DIR_UP];
  assign down  = out_q[DIR_DOWN];
  assign left  = out_q[DIR_LEFT];
  assign right = out_q[DIR_RIGHT];
  assign held  = {held_v[DIR_UP], held_v[DIR_DOWN], held_v[DIR_LEFT], held_v[DIR_RIGHT]};
endmodule
